instr_fetch_stage: RTL and testbench

- Fetch stage that sits directly upstream of the 16-bit byte-addressed instruction memory and feeds the decode stage.
- Holds the program counter and drives the memory address combinationally.
- Captures the returned little-endian 16-bit instruction word into the IF/ID pipeline register.
- Handles decode-side stalls, branch redirects with a one-bubble flush, and halting on the invalid-instruction encoding.

---
 rtl/instr_fetch_stage.sv | 113 +++++++++++
 tb/tb_instr_fetch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// ============================================================================
// Module      : instr_fetch_stage
// Description : PC and IF/ID register for a 16-bit byte-addressed instruction
//               memory. Handles decode stalls, branch redirects and halting
//               on INVALID_WORD. Define IFETCH_PERF_COUNT_EN for counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] PC_STEP      = 16'd2,
    parameter logic [15:0] INVALID_WORD = 16'hEFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic [15:0] IMemAddress,
    input  logic [15:0] IMemReadData,
    output logic [15:0] IFID_Instr,
    output logic [15:0] IFID_PC,
    output logic        IFID_Valid,
    output logic        Halted,
    output logic [15:0] FetchCount,
    output logic [15:0] StallCount
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HALT  = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_ifid_pc;
    logic        r_valid;

    logic        w_fetch_ok;
    logic        w_load;
    logic        w_stall_cnt;
    logic        w_unused_tgt_lsb;

    // Instructions are halfword aligned, so the target LSB is discarded.
    assign w_unused_tgt_lsb = BranchTarget[0];

    assign w_fetch_ok  = !BranchTaken && (r_state == S_FETCH) && !Stall;
    assign w_load      = w_fetch_ok && (IMemReadData != INVALID_WORD);
    assign w_stall_cnt = !BranchTaken && (r_state == S_FETCH) && Stall;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= 16'h0000;
            r_ifid_pc <= 16'h0000;
            r_valid   <= 1'b0;
        end else if (BranchTaken) begin
            // One bubble: IF/ID is invalidated while the target is fetched.
            r_state <= S_FETCH;
            r_pc    <= {BranchTarget[15:1], 1'b0};
            r_instr <= 16'h0000;
            r_valid <= 1'b0;
        end else if (w_fetch_ok) begin
            if (w_load) begin
                r_instr   <= IMemReadData;
                r_ifid_pc <= r_pc;
                r_valid   <= 1'b1;
                r_pc      <= r_pc + PC_STEP;
            end else begin
                r_instr <= 16'h0000;
                r_valid <= 1'b0;
                r_state <= S_HALT;
            end
        end
    end

`ifdef IFETCH_PERF_COUNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_fetch_cnt <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else begin
            if (w_load && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_stall_cnt && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign StallCount = r_stall_cnt;
`else
    logic w_unused_stall_cnt;
    assign w_unused_stall_cnt = w_stall_cnt;
    assign FetchCount = 16'h0000;
    assign StallCount = 16'h0000;
`endif

    assign IMemAddress = r_pc;
    assign IFID_Instr  = r_instr;
    assign IFID_PC     = r_ifid_pc;
    assign IFID_Valid  = r_valid;
    assign Halted      = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// Module      : tb_instr_fetch_stage
// Description : Self-checking bench for instr_fetch_stage with a byte memory
//               model and a scoreboard of expected post-edge states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_stage;

    logic        Clock;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] IMemAddress;
    logic [15:0] IMemReadData;
    logic [15:0] IFID_Instr;
    logic [15:0] IFID_PC;
    logic        IFID_Valid;
    logic        Halted;
    logic [15:0] FetchCount;
    logic [15:0] StallCount;

    logic [7:0]  mem [0:65535];

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic [15:0] fc;
        logic [15:0] sc;
        logic        valid;
        logic        halt;
    } st_t;

    st_t m;
    st_t q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    instr_fetch_stage dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .IMemAddress (IMemAddress),
        .IMemReadData(IMemReadData),
        .IFID_Instr  (IFID_Instr),
        .IFID_PC     (IFID_PC),
        .IFID_Valid  (IFID_Valid),
        .Halted      (Halted),
        .FetchCount  (FetchCount),
        .StallCount  (StallCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign IMemReadData = {mem[IMemAddress + 16'd1], mem[IMemAddress]};

    function automatic logic [15:0] rd(input logic [15:0] a);
        return {mem[a + 16'd1], mem[a]};
    endfunction

    task automatic wr(input logic [15:0] a, input logic [15:0] w);
        mem[a]         = w[7:0];
        mem[a + 16'd1] = w[15:8];
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural next-state of the fetch stage given current inputs.
    function automatic st_t model_next(input st_t s);
        st_t n;
        logic [15:0] w;
        n = s;
        if (Reset) begin
            n = '0;
            n.pc = 16'h0000;
        end else if (BranchTaken) begin
            n.pc    = BranchTarget & 16'hFFFE;
            n.instr = 16'h0000;
            n.valid = 1'b0;
            n.halt  = 1'b0;
        end else if (s.halt) begin
            n = s;
        end else if (Stall) begin
            if (s.sc != 16'hFFFF) n.sc = s.sc + 16'd1;
        end else begin
            w = rd(s.pc);
            if (w == 16'hEFFF) begin
                n.instr = 16'h0000;
                n.valid = 1'b0;
                n.halt  = 1'b1;
            end else begin
                n.instr = w;
                n.ipc   = s.pc;
                n.valid = 1'b1;
                n.pc    = s.pc + 16'd2;
                if (s.fc != 16'hFFFF) n.fc = s.fc + 16'd1;
            end
        end
        return n;
    endfunction

    task automatic tick();
        st_t e;
        q.push_back(model_next(m));
        @(posedge Clock);
        #1;
        e = q.pop_front();
        chk("sb_addr",  IMemAddress, e.pc);
        chk("sb_instr", IFID_Instr,  e.instr);
        chk("sb_ipc",   IFID_PC,     e.ipc);
        chk("sb_valid", {15'd0, IFID_Valid}, {15'd0, e.valid});
        chk("sb_halt",  {15'd0, Halted},     {15'd0, e.halt});
`ifdef IFETCH_PERF_COUNT_EN
        chk("sb_fcnt", FetchCount, e.fc);
        chk("sb_scnt", StallCount, e.sc);
`else
        chk("sb_fcnt", FetchCount, 16'h0000);
        chk("sb_scnt", StallCount, 16'h0000);
`endif
        m = e;
        @(negedge Clock);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) wr(16'(2 * i), 16'h1000 + 16'(i));
        wr(16'h0000, 16'h0120);
        wr(16'h0002, 16'h0121);
        wr(16'h0004, 16'h0343);
        wr(16'h0024, 16'h8890);
        wr(16'h0032, 16'hEFFF);

        m = '0;
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;

        tick(); tick();
        chk("rst_valid", {15'd0, IFID_Valid}, 16'd0);
        chk("rst_addr", IMemAddress, 16'h0000);

        Reset = 1'b0;
        tick();
        chk("f1_instr", IFID_Instr, 16'h0120);
        chk("f1_pc", IFID_PC, 16'h0000);
        chk("f1_valid", {15'd0, IFID_Valid}, 16'd1);
        chk("f1_addr", IMemAddress, 16'h0002);
        tick();
        chk("f2_instr", IFID_Instr, 16'h0121);
        chk("f2_pc", IFID_PC, 16'h0002);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", IFID_PC, 16'h0002);
            chk("stall_addr", IMemAddress, 16'h0004);
        end
        Stall = 1'b0;
        tick();
        chk("rel_instr", IFID_Instr, 16'h0343);
        chk("rel_pc", IFID_PC, 16'h0004);
`ifdef IFETCH_PERF_COUNT_EN
        chk("rel_stallcnt", StallCount, 16'd3);
`endif
        tick();
        chk("pre_br_addr", IMemAddress, 16'h0008);

        BranchTaken = 1'b1; BranchTarget = 16'h0025;
        tick();
        chk("br_addr", IMemAddress, 16'h0024);
        chk("br_valid", {15'd0, IFID_Valid}, 16'd0);
        BranchTaken = 1'b0;
        tick();
        chk("br_instr", IFID_Instr, 16'h8890);
        chk("br_pc", IFID_PC, 16'h0024);

        begin
            int budget = 40;
            while (IMemAddress != 16'h0032 && budget > 0) begin
                tick();
                budget--;
            end
            chk("reach_0032", IMemAddress, 16'h0032);
        end
        // An invalid word seen while stalled must not halt.
        Stall = 1'b1;
        tick();
        chk("stall_inv_halt", {15'd0, Halted}, 16'd0);
        Stall = 1'b0;
        tick();
        chk("halt", {15'd0, Halted}, 16'd1);
        chk("halt_valid", {15'd0, IFID_Valid}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_addr", IMemAddress, 16'h0032);
        end

        BranchTaken = 1'b1; BranchTarget = 16'h0000;
        tick();
        chk("unhalt", {15'd0, Halted}, 16'd0);
        BranchTaken = 1'b0;
        tick();
        chk("unhalt_instr", IFID_Instr, 16'h0120);

        wr(16'hFFFE, 16'h0000);
        BranchTaken = 1'b1; BranchTarget = 16'hFFFF;
        tick();
        chk("wrap_br_addr", IMemAddress, 16'hFFFE);
        BranchTaken = 1'b0;
        tick();
        chk("wrap_pc", IFID_PC, 16'hFFFE);
        chk("wrap_addr", IMemAddress, 16'h0000);

        Stall = 1'b1;
        tick();
        Reset = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'h0040;
        tick();
        chk("rst2_addr", IMemAddress, 16'h0000);
        chk("rst2_instr", IFID_Instr, 16'h0000);
        chk("rst2_pc", IFID_PC, 16'h0000);
        chk("rst2_valid", {15'd0, IFID_Valid}, 16'd0);
        chk("rst2_halt", {15'd0, Halted}, 16'd0);
        chk("rst2_fcnt", FetchCount, 16'h0000);
        chk("rst2_scnt", StallCount, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
